solve_log: RTL and testbench

- Downstream of the solver top. Records the move stream the solver emits (one move code per applied step) into a bounded log.
- Tracks solve outcome: solved, failed, or overflowed.
- Exposes the recorded solution to the host-side register block:
  - a flat packed vector for bulk readout;
  - an indexed read port with 1-cycle latency.

---
 rtl/solve_log.sv | 133 +++++++++++++
 tb/tb_solve_log.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/solve_log.sv
// solve_log: bounded move log with solve outcome tracking
// and a registered indexed read port for the host.
module solve_log #(
  parameter int MAX_MOVES = 10,
  parameter int MOVE_W    = 4,
  parameter int CNT_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        clear,
  input  logic                        move_valid,
  input  logic [MOVE_W-1:0]           move,
  input  logic                        solved,
  input  logic                        fail,
  input  logic                        rd_en,
  input  logic [CNT_W-1:0]            rd_idx,
  output logic [MOVE_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic [CNT_W-1:0]            count,
  output logic [1:0]                  status,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [MOVE_W*MAX_MOVES-1:0] moves_flat
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOG    = 2'd1,
    S_SOLVED = 2'd2,
    S_FAILED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_MOVES);

  state_t state, state_nx;

  logic [MOVE_W-1:0] mem [MAX_MOVES];
  logic clr, wr, ovf_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    wr       = 1'b0;
    ovf_set  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (clear) begin
          clr = 1'b1;
        end else if (start) begin
          state_nx = S_LOG;
          clr      = 1'b1;
        end
      end
      S_LOG: begin
        if (clear) begin
          state_nx = S_IDLE;
          clr      = 1'b1;
        end else if (fail) begin
          state_nx = S_FAILED;
        end else if (move_valid && count == MAX_C) begin
          state_nx = S_FAILED;
          ovf_set  = 1'b1;
        end else if (move_valid) begin
          wr = 1'b1;
          if (solved) state_nx = S_SOLVED;
        end else if (solved) begin
          state_nx = S_SOLVED;
        end
      end
      S_SOLVED, S_FAILED: begin
        if (clear) begin
          state_nx = S_IDLE;
          clr      = 1'b1;
        end else if (start) begin
          state_nx = S_LOG;
          clr      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < MAX_MOVES; i++) mem[i] <= '0;
    end else if (clr) begin
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < MAX_MOVES; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[count] <= move;
        count      <= count + 1'b1;
      end
      if (ovf_set) overflow <= 1'b1;
    end
  end

  // Read samples pre-edge contents, so a same-cycle write is not seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (rd_idx < count) rd_data <= mem[rd_idx];
        else                rd_data <= '1;
      end
    end
  end

  always_comb begin
    moves_flat = '0;
    for (int i = 0; i < MAX_MOVES; i++) begin
      if (CNT_W'(i) < count)
        moves_flat[i*MOVE_W +: MOVE_W] = mem[i];
    end
  end

  assign status = state;
  assign busy   = (state == S_LOG);
  assign done   = (state == S_SOLVED) || (state == S_FAILED);

endmodule

// File: tb/tb_solve_log.sv
// tb_solve_log: directed vector table plus hand sequences
// for async reset behaviour of solve_log.
module tb_solve_log;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        move_valid = 1'b0;
  logic [3:0]  move = '0;
  logic        solved = 1'b0;
  logic        fail = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_idx = '0;
  logic [3:0]  rd_data;
  logic        rd_valid;
  logic [3:0]  count;
  logic [1:0]  status;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [39:0] moves_flat;

  int checks = 0;
  int failures = 0;

  solve_log dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .move_valid(move_valid), .move(move), .solved(solved),
    .fail(fail), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .status(status), .busy(busy), .done(done),
    .overflow(overflow), .moves_flat(moves_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, cl, mv;
    logic [3:0]  mo;
    logic        so, fa, re;
    logic [3:0]  ri;
    logic [1:0]  es;
    logic [3:0]  ec;
    logic        eo;
    logic [39:0] ef;
    logic        erv;
    logic [3:0]  erd;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic st, cl, mv, input logic [3:0] mo,
    input logic so, fa, re, input logic [3:0] ri,
    input logic [1:0] es, input logic [3:0] ec, input logic eo,
    input logic [39:0] ef, input logic erv, input logic [3:0] erd);
    vec_t v;
    v.st = st; v.cl = cl; v.mv = mv; v.mo = mo;
    v.so = so; v.fa = fa; v.re = re; v.ri = ri;
    v.es = es; v.ec = ec; v.eo = eo; v.ef = ef;
    v.erv = erv; v.erd = erd;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; clear = 0; move_valid = 0; move = 0;
    solved = 0; fail = 0; rd_en = 0; rd_idx = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [39:0] f;
    idle_inputs();
    rst_n = 0;
    #12;
    chk("reset_status", status, 2'd0);
    chk("reset_count", count, 4'd0);
    chk("reset_ovf", overflow, 1'b0);
    chk("reset_flat", moves_flat, 40'h0);
    chk("reset_rdv", rd_valid, 1'b0);
    chk("reset_rdd", rd_data, 4'h0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // test 1: moves 3,7,1 then solved, reads
    add(1,0,0,0, 0,0,0,0, 1,0,0,40'h0,     0,0);
    add(0,0,1,3, 0,0,0,0, 1,1,0,40'h3,     0,0);
    add(0,0,1,7, 0,0,0,0, 1,2,0,40'h73,    0,0);
    add(0,0,1,1, 0,0,0,0, 1,3,0,40'h173,   0,0);
    add(0,0,0,0, 1,0,0,0, 2,3,0,40'h173,   0,0);
    add(0,0,0,0, 0,0,1,1, 2,3,0,40'h173,   1,4'h7);
    add(0,0,0,0, 0,0,1,5, 2,3,0,40'h173,   1,4'hF);
    add(0,0,1,9, 1,1,0,0, 2,3,0,40'h173,   0,0);
    // test 2: fill to 10 then overflow
    add(1,0,0,0, 0,0,0,0, 1,0,0,40'h0,     0,0);
    f = '0;
    for (int k = 0; k < 10; k++) begin
      f = f | (40'(k) << (4*k));
      add(0,0,1,4'(k), 0,0,0,0, 1,4'(k+1),0,f, 0,0);
    end
    add(0,0,1,5, 0,0,0,0, 3,10,1,f,        0,0);
    add(0,0,0,0, 0,0,1,9, 3,10,1,f,        1,4'h9);
    add(0,0,0,0, 0,0,1,10,3,10,1,f,        1,4'hF);
    // test 3: final move with solved; read during write not forwarded
    add(1,0,0,0, 0,0,0,0, 1,0,0,40'h0,     0,0);
    add(0,0,1,2, 0,0,1,0, 1,1,0,40'h2,     1,4'hF);
    add(0,0,1,6, 0,0,0,0, 1,2,0,40'h62,    0,0);
    add(0,0,1,4, 1,0,0,0, 2,3,0,40'h462,   0,0);
    add(0,0,0,0, 0,0,1,2, 2,3,0,40'h462,   1,4'h4);
    // test 4: fail with move, then restart with same-cycle move
    add(1,0,0,0, 0,0,0,0, 1,0,0,40'h0,     0,0);
    add(0,0,1,1, 0,0,0,0, 1,1,0,40'h1,     0,0);
    add(0,0,1,2, 0,0,0,0, 1,2,0,40'h21,    0,0);
    add(0,0,1,3, 0,0,0,0, 1,3,0,40'h321,   0,0);
    add(0,0,1,4, 0,0,0,0, 1,4,0,40'h4321,  0,0);
    add(0,0,1,8, 0,1,0,0, 3,4,0,40'h4321,  0,0);
    add(1,0,1,9, 0,0,0,0, 1,0,0,40'h0,     0,0);
    // test 6: clear beats start from SOLVED
    add(0,0,1,1, 0,0,0,0, 1,1,0,40'h1,     0,0);
    add(0,0,1,2, 0,0,0,0, 1,2,0,40'h21,    0,0);
    add(0,0,1,3, 1,0,0,0, 2,3,0,40'h321,   0,0);
    add(1,1,0,0, 0,0,0,0, 0,0,0,40'h0,     0,0);
    add(0,0,0,0, 1,0,0,0, 0,0,0,40'h0,     0,0);
    add(0,0,1,7, 0,0,1,0, 0,0,0,40'h0,     1,4'hF);

    foreach (vq[i]) begin
      start = vq[i].st; clear = vq[i].cl;
      move_valid = vq[i].mv; move = vq[i].mo;
      solved = vq[i].so; fail = vq[i].fa;
      rd_en = vq[i].re; rd_idx = vq[i].ri;
      tick();
      idle_inputs();
      chk($sformatf("v%0d_status", i), status, vq[i].es);
      chk($sformatf("v%0d_count", i), count, vq[i].ec);
      chk($sformatf("v%0d_ovf", i), overflow, vq[i].eo);
      chk($sformatf("v%0d_flat", i), moves_flat, vq[i].ef);
      chk($sformatf("v%0d_busy", i), busy, vq[i].es == 2'd1);
      chk($sformatf("v%0d_done", i), done, vq[i].es[1]);
      chk($sformatf("v%0d_rdv", i), rd_valid, vq[i].erv);
      if (vq[i].erv)
        chk($sformatf("v%0d_rdd", i), rd_data, vq[i].erd);
    end

    // test 5: async reset mid-session
    start = 1; tick(); start = 0;
    for (int k = 0; k < 5; k++) begin
      move_valid = 1; move = 4'(k + 1); tick();
    end
    move_valid = 0;
    chk("t5_pre_count", count, 4'd5);
    chk("t5_pre_flat", moves_flat, 40'h54321);
    #3;
    rst_n = 0;
    #1;
    chk("t5_async_status", status, 2'd0);
    chk("t5_async_count", count, 4'd0);
    chk("t5_async_flat", moves_flat, 40'h0);
    @(negedge clk);
    rst_n = 1;
    move_valid = 1; move = 4'h6; solved = 1;
    tick(); tick();
    idle_inputs();
    chk("t5_ignored_status", status, 2'd0);
    chk("t5_ignored_count", count, 4'd0);
    start = 1; tick(); start = 0;
    move_valid = 1; move = 4'hA; tick(); move_valid = 0;
    chk("t5_restart_count", count, 4'd1);
    chk("t5_restart_flat", moves_flat, 40'hA);
    chk("t5_restart_status", status, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
